// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory.
// A little-endian byte stream is packed into 32-bit words and written
// sequentially from word 0. The fetch read port is combinational and
// stays live through reset. core_hold keeps the core in reset while
// a program is being loaded and for the single DONE cycle after it.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              core_hold,
  output logic              load_done,
  output logic              busy,
  input  logic [63:0]       rd_addr,
  output logic [31:0]       rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Memory depth expressed in the width of num_words, used for clamping.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  logic [1:0]        state_q,      state_d;
  logic [23:0]       word_buf_q,   word_buf_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  logic [31:0] mem_q [DEPTH];

  // Only the word-index bits of the fetch address matter; the rest are
  // intentionally ignored so the index wraps modulo DEPTH.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_addr[63:ADDR_W+2], rd_addr[1:0]};

  // Next-state logic: FSM transitions, byte packing and word write request.
  always_comb begin
    state_d      = state_q;
    word_buf_d   = word_buf_q;
    byte_cnt_d   = byte_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    words_left_d = words_left_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q;
    // The fourth byte goes straight to memory with the three buffered ones.
    mem_wdata    = {byte_data, word_buf_q};

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_LOAD;
            words_left_d = (num_words > DEPTH_W) ? DEPTH_W : num_words;
            wr_ptr_d     = '0;
            byte_cnt_d   = 2'd0;
          end
        end
      end

      S_LOAD: begin
        if (byte_valid) begin
          if (byte_cnt_q == 2'd3) begin
            mem_we       = 1'b1;
            byte_cnt_d   = 2'd0;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == ONE_W) begin
              state_d = S_DONE;
            end
          end else begin
            case (byte_cnt_q)
              2'd0:    word_buf_d[7:0]   = byte_data;
              2'd1:    word_buf_d[15:8]  = byte_data;
              default: word_buf_d[23:16] = byte_data;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and packing registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_buf_q   <= '0;
      byte_cnt_q   <= 2'd0;
      wr_ptr_q     <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      word_buf_q   <= word_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      words_left_q <= words_left_d;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign byte_ready = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign core_hold  = (state_q == S_LOAD) || (state_q == S_DONE);
  assign load_done  = (state_q == S_DONE);

  // Combinational fetch read: old word until the write edge, new word after.
  assign rd_data = mem_q[rd_addr[ADDR_W+1:2]];

endmodule
